// File: rtl/fetch_unit.sv
// IF stage: owns the PC, addresses the instruction ROM and holds the IF/ID register.
// Build with FETCH_PERF_EN defined to add saturating stall/flush counters.
module fetch_unit #(
  parameter int                PC_W      = 16,
  parameter int                DATA_W    = 32,
  parameter int                ROM_WORDS = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [PC_W-1:0]   instr_pc,
  output logic              instr_valid,
  output logic [PC_W-1:0]   pc,
  output logic [15:0]       cc,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'((ROM_WORDS - 1) * 4);

  state_t state;

  // Target byte address is forced word aligned.
  logic unused_rpc_lsbs;
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  assign rom_addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      instr       <= NOP_WORD;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      cc          <= '0;
      halted      <= 1'b0;
    end else begin
      cc <= cc + 16'd1;
      if (redirect) begin
        pc          <= {redirect_pc[PC_W-1:2], 2'b00};
        instr       <= NOP_WORD;
        instr_valid <= 1'b0;
        state       <= RUN;
        halted      <= 1'b0;
      end else if (state == HALT) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end else if (!stall) begin
        instr       <= rom_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        // A redirect past the last word still fetches once, then stops.
        if (pc >= LAST_PC) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          pc <= pc + PC_W'(4);
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (state == RUN && stall && !redirect && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (redirect && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
